// File: rtl/triangle_channel.sv
// NES APU triangle channel: 11-bit timer, linear counter, length counter and
// a 32-step sequencer that produces the 4-bit triangle level for the mixer.
module triangle_channel #(
    parameter bit SILENCE_ULTRASONIC = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_ce,
    input  logic       reg_we,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_wdata,
    input  logic       enable,
    input  logic       quarter_frame,
    input  logic       half_frame,
    output logic [3:0] tr_out,
    output logic       length_nz
);

    logic [10:0] period_q, period_d;
    logic [10:0] timer_q, timer_d;
    logic [4:0]  step_q, step_d;
    logic [6:0]  linear_q, linear_d;
    logic [6:0]  reload_val_q, reload_val_d;
    logic        reload_flag_q, reload_flag_d;
    logic        control_q, control_d;
    logic [7:0]  length_q, length_d;
    logic [3:0]  tr_q, tr_d;

    logic wr_4008, wr_400a, wr_400b;
    logic tick, silent;

    function automatic logic [7:0] len_lut(input logic [4:0] idx);
        case (idx)
            5'd0:  len_lut = 8'd10;
            5'd1:  len_lut = 8'd254;
            5'd2:  len_lut = 8'd20;
            5'd3:  len_lut = 8'd2;
            5'd4:  len_lut = 8'd40;
            5'd5:  len_lut = 8'd4;
            5'd6:  len_lut = 8'd80;
            5'd7:  len_lut = 8'd6;
            5'd8:  len_lut = 8'd160;
            5'd9:  len_lut = 8'd8;
            5'd10: len_lut = 8'd60;
            5'd11: len_lut = 8'd10;
            5'd12: len_lut = 8'd14;
            5'd13: len_lut = 8'd12;
            5'd14: len_lut = 8'd26;
            5'd15: len_lut = 8'd14;
            5'd16: len_lut = 8'd12;
            5'd17: len_lut = 8'd16;
            5'd18: len_lut = 8'd24;
            5'd19: len_lut = 8'd18;
            5'd20: len_lut = 8'd48;
            5'd21: len_lut = 8'd20;
            5'd22: len_lut = 8'd96;
            5'd23: len_lut = 8'd22;
            5'd24: len_lut = 8'd192;
            5'd25: len_lut = 8'd24;
            5'd26: len_lut = 8'd72;
            5'd27: len_lut = 8'd26;
            5'd28: len_lut = 8'd16;
            5'd29: len_lut = 8'd28;
            5'd30: len_lut = 8'd32;
            default: len_lut = 8'd30;
        endcase
    endfunction

    assign wr_4008 = reg_we && (reg_addr == 2'd0);
    assign wr_400a = reg_we && (reg_addr == 2'd2);
    assign wr_400b = reg_we && (reg_addr == 2'd3);

    // Periods below 2 would toggle far above audible range; freezing avoids aliasing pops.
    assign silent = SILENCE_ULTRASONIC && (period_q < 11'd2);

    always_comb begin
        period_d      = period_q;
        timer_d       = timer_q;
        step_d        = step_q;
        linear_d      = linear_q;
        reload_val_d  = reload_val_q;
        reload_flag_d = reload_flag_q;
        control_d     = control_q;
        length_d      = length_q;
        tick          = 1'b0;

        if (wr_4008) begin
            control_d    = reg_wdata[7];
            reload_val_d = reg_wdata[6:0];
        end
        if (wr_400a) period_d[7:0]  = reg_wdata;
        if (wr_400b) period_d[10:8] = reg_wdata[2:0];

        if (cpu_ce) begin
            if (timer_q == 11'd0) begin
                timer_d = period_q;
                tick    = 1'b1;
            end else begin
                timer_d = timer_q - 11'd1;
            end
        end

        if (tick && (linear_q != 7'd0) && (length_q != 8'd0) && !silent)
            step_d = step_q + 5'd1;

        // Quarter tick sees the flag as it stood before any coincident $400B write.
        if (quarter_frame) begin
            if (reload_flag_q)           linear_d = reload_val_q;
            else if (linear_q != 7'd0)   linear_d = linear_q - 7'd1;
            if (!control_q)              reload_flag_d = 1'b0;
        end
        if (wr_400b) reload_flag_d = 1'b1;

        if (!enable)
            length_d = 8'd0;
        else if (wr_400b)
            length_d = len_lut(reg_wdata[7:3]);
        else if (half_frame && (length_q != 8'd0) && !control_q)
            length_d = length_q - 8'd1;
    end

    // Steps 0..15 descend 15..0, steps 16..31 ascend 0..15.
    assign tr_d = step_q[4] ? step_q[3:0] : ~step_q[3:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q      <= '0;
            timer_q       <= '0;
            step_q        <= '0;
            linear_q      <= '0;
            reload_val_q  <= '0;
            reload_flag_q <= 1'b0;
            control_q     <= 1'b0;
            length_q      <= '0;
            tr_q          <= 4'd15;
        end else begin
            period_q      <= period_d;
            timer_q       <= timer_d;
            step_q        <= step_d;
            linear_q      <= linear_d;
            reload_val_q  <= reload_val_d;
            reload_flag_q <= reload_flag_d;
            control_q     <= control_d;
            length_q      <= length_d;
            tr_q          <= tr_d;
        end
    end

    assign tr_out    = tr_q;
    assign length_nz = (length_q != 8'd0);

endmodule

// File: tb/tb_triangle_channel.sv
// Directed bench for triangle_channel; expected levels go through a scoreboard queue.
module tb_triangle_channel;

    logic       clk = 1'b0, reset_n = 1'b0, cpu_ce = 1'b0, reg_we = 1'b0;
    logic       enable = 1'b0, quarter_frame = 1'b0, half_frame = 1'b0;
    logic [1:0] reg_addr = '0;
    logic [7:0] reg_wdata = '0;
    logic [3:0] tr_out;
    logic       length_nz;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    triangle_channel #(.SILENCE_ULTRASONIC(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_ce(cpu_ce), .reg_we(reg_we),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .enable(enable),
        .quarter_frame(quarter_frame), .half_frame(half_frame),
        .tr_out(tr_out), .length_nz(length_nz)
    );

    function automatic int tri_lvl(input int s);
        int m;
        m = s % 32;
        return (m < 16) ? 15 - m : m - 16;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_tr(input int v);
        exp_q.push_back(v);
    endtask

    task automatic pop_tr(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s: scoreboard empty, observed %0d expected none", tag, tr_out);
        end else begin
            chk(tag, int'(tr_out), exp_q.pop_front());
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit qf, input bit hf);
        quarter_frame = qf;
        half_frame    = hf;
        @(posedge clk); #1;
        quarter_frame = 1'b0;
        half_frame    = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d,
                      input bit qf = 1'b0, input bit hf = 1'b0);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        quarter_frame = qf; half_frame = hf;
        @(posedge clk); #1;
        reg_we = 1'b0; quarter_frame = 1'b0; half_frame = 1'b0;
    endtask

    task automatic run_ce(input int n);
        cpu_ce = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        cpu_ce = 1'b0;
    endtask

    initial begin
        // Reset state and free-running timer with counters at zero
        idle(2);
        chk("reset_tr", int'(tr_out), 15);
        chk("reset_nz", int'(length_nz), 0);
        reset_n = 1'b1;
        idle(1);
        for (int i = 0; i < 5; i++) begin
            cpu_ce = 1'b1; idle(1); cpu_ce = 1'b0; idle(1);
        end
        chk("ce_only_tr", int'(tr_out), 15);

        // Full waveform at period 2: one step every 3 cpu_ce, wrapping past 31
        enable = 1'b1;
        wr(2'd0, 8'h81);
        wr(2'd2, 8'h02);
        wr(2'd3, 8'h08);
        pulse(1'b1, 1'b0);
        chk("load_nz", int'(length_nz), 1);
        for (int k = 1; k <= 70; k++) begin
            push_tr(tri_lvl(k));
            run_ce(3);
            pop_tr("seq");
        end

        // Linear counter reaching zero freezes the sequencer
        wr(2'd0, 8'h01);
        wr(2'd3, 8'h08);
        pulse(1'b1, 1'b0);
        push_tr(tri_lvl(71)); run_ce(3); pop_tr("linear1_step");
        pulse(1'b1, 1'b0);
        push_tr(tri_lvl(71)); run_ce(30); pop_tr("linear0_freeze");

        // Length counter runs out under half_frame, then halted variant
        wr(2'd0, 8'h7F);
        wr(2'd3, 8'h18);
        pulse(1'b1, 1'b0);
        chk("len2_nz", int'(length_nz), 1);
        pulse(1'b0, 1'b1);
        chk("len1_nz", int'(length_nz), 1);
        push_tr(tri_lvl(72)); run_ce(3); pop_tr("len1_step");
        pulse(1'b0, 1'b1);
        chk("len0_nz", int'(length_nz), 0);
        push_tr(tri_lvl(72)); run_ce(30); pop_tr("len0_freeze");
        wr(2'd0, 8'hFF);
        wr(2'd3, 8'h18);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        chk("halt_nz", int'(length_nz), 1);

        // Enable gating and load-versus-decrement priority
        enable = 1'b0;
        idle(1);
        chk("disable_nz", int'(length_nz), 0);
        wr(2'd3, 8'h18);
        chk("disabled_load_nz", int'(length_nz), 0);
        enable = 1'b1;
        wr(2'd0, 8'h7F);
        wr(2'd3, 8'h18, 1'b0, 1'b1);
        chk("load_hf_nz", int'(length_nz), 1);
        pulse(1'b0, 1'b1);
        chk("load_hf_dec1", int'(length_nz), 1);
        pulse(1'b0, 1'b1);
        chk("load_hf_dec2", int'(length_nz), 0);
        wr(2'd3, 8'h00);
        repeat (9) pulse(1'b0, 1'b1);
        chk("len10_after9", int'(length_nz), 1);
        pulse(1'b0, 1'b1);
        chk("len10_after10", int'(length_nz), 0);
        pulse(1'b0, 1'b1);
        chk("len_floor", int'(length_nz), 0);

        // Ultrasonic periods hold the level with both counters nonzero
        wr(2'd0, 8'h81);
        wr(2'd3, 8'h08);
        pulse(1'b1, 1'b0);
        wr(2'd2, 8'h01);
        push_tr(tri_lvl(72)); run_ce(30); pop_tr("period1_hold");
        wr(2'd2, 8'h00);
        push_tr(tri_lvl(72)); run_ce(30); pop_tr("period0_hold");

        // Asynchronous reset mid-run
        wr(2'd2, 8'h02);
        cpu_ce = 1'b1;
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_tr", int'(tr_out), 15);
        chk("async_rst_nz", int'(length_nz), 0);
        cpu_ce = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Restart from step 0, then $400B write coincident with quarter_frame
        push_tr(15); idle(1); pop_tr("post_rst_tr");
        wr(2'd0, 8'h01);
        wr(2'd2, 8'h02);
        wr(2'd3, 8'h08);
        pulse(1'b1, 1'b0);
        push_tr(14); run_ce(3); pop_tr("restart_step1");
        pulse(1'b1, 1'b0);
        push_tr(14); run_ce(3); pop_tr("restart_freeze");
        wr(2'd3, 8'h08, 1'b1, 1'b0);
        push_tr(14); run_ce(3); pop_tr("qf_write_prior_flag");
        pulse(1'b1, 1'b0);
        push_tr(13); run_ce(3); pop_tr("qf_write_flag_set");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/triangle_channel.md
TRIANGLE_CHANNEL -- requirements
Module: triangle_channel

Interface
REQ-001 Parameter: SILENCE_ULTRASONIC, default 1, meaning 1 = sequencer frozen while timer period < 2.
REQ-002 Port: clk  input  1  system clock, all state on rising edge.
REQ-003 Port: reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: cpu_ce  input  1  one-cycle pulse per CPU clock; timer advances only when high.
REQ-005 Port: reg_we  input  1  register write strobe, one clk cycle.
REQ-006 Port: reg_addr  input  2  register select: 0=$4008, 1=$4009 (ignored), 2=$400A, 3=$400B.
REQ-007 Port: reg_wdata  input  8  register write data.
REQ-008 Port: enable  input  1  channel enable, $4015 bit 2 level.
REQ-009 Port: quarter_frame  input  1  frame-counter quarter tick, one-cycle pulse.
REQ-010 Port: half_frame  input  1  frame-counter half tick, one-cycle pulse.
REQ-011 Port: tr_out  output  4  triangle level to the mixer (tnd table index term 3*tr_out).
REQ-012 Port: length_nz  output  1  high when length counter != 0 (status readback).

Function
REQ-013 $4008 write SHALL store control flag = bit7 (length halt / linear control) and linear reload value = bits6:0.
REQ-014 $400A write SHALL store timer period bits7:0.
REQ-015 $400B write SHALL store timer period bits10:8 = data2:0, set linear reload flag, and load length counter from table[data7:3] when enable=1.
REQ-016 Length table (index 0..31): 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
REQ-017 enable=0 SHALL force length counter to 0 every cycle; a $400B write while enable=0 SHALL NOT load it.
REQ-018 Timer: 11-bit down counter; on cpu_ce, if 0 reload with period and emit step tick, else decrement.
REQ-019 Step tick SHALL advance sequencer 5-bit step (31 wraps to 0) only when linear counter != 0 and length counter != 0.
REQ-020 With SILENCE_ULTRASONIC=1 and period < 2, sequencer SHALL hold its step.
REQ-021 tr_out = 15-step for step 0..15, step-16 for step 16..31 (15..0,0..15); registered, one clk after step change.
REQ-022 quarter_frame: if reload flag set, linear <= reload value; else if linear != 0, linear decrements; then if control flag = 0, reload flag clears.
REQ-023 half_frame: if length != 0 and control flag = 0, length decrements by 1; never below 0.
REQ-024 $400B write coincident with half_frame: load wins, no decrement that cycle.
REQ-025 $400B write coincident with quarter_frame: quarter_frame acts on prior flag state; reload flag ends set.
REQ-026 enable=0 coincident with $400B write: length = 0.
REQ-027 Sequencer holding (counter zero) SHALL keep tr_out at current level, not force 0.
REQ-028 length_nz combinational from length counter.

Reset
REQ-029 reset_n low asynchronously clears: period, timer, step, linear counter, reload value, reload flag, control flag, length counter to 0.
REQ-030 Reset values: tr_out = 15 (step 0), length_nz = 0.
REQ-031 Reset asserted mid-sequence SHALL abandon state immediately; first step after release starts from step 0.

Verification
REQ-032 Reset -> tr_out=15, length_nz=0; cpu_ce pulses only -> tr_out stays 15.
REQ-033 enable=1; $4008=0x81; $400A=0x02; $400B=0x08 (len idx1=254); one quarter_frame; cpu_ce continuous -> step advances every 3 cpu_ce, tr_out 15,14..0,0,1..15, repeat.
REQ-034 $4008=0x01 (control 0), $400B load, quarter_frame x2 -> linear 1 then 0; sequencer freezes at current tr_out.
REQ-035 $4008=0x7F, $400B=0x18 (idx3=2); half_frame x2 -> length_nz 1 then 0; sequencer freezes; $4008=0xFF variant -> length stays 2.
REQ-036 enable=0 then $400B write -> length_nz=0; enable=1, $400B write concurrent with half_frame -> length equals table value exactly.
REQ-037 Period 0 or 1 with counters nonzero -> tr_out constant; reset pulse mid-run -> tr_out=15 immediately.
